// File: rtl/seq_mac_mult.sv
// Sequential shift-and-add multiplier (WIDTH iterations) with optional
// accumulate into a wrapping ACC_WIDTH register and a sticky overflow flag.
module seq_mac_mult #(
  parameter int WIDTH     = 4,
  parameter int ACC_WIDTH = 2*WIDTH+4
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [WIDTH-1:0]     a,
  input  logic [WIDTH-1:0]     b,
  input  logic                 op_signed,
  input  logic                 op_acc,
  input  logic                 acc_clr,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [2*WIDTH-1:0]   product,
  output logic [ACC_WIDTH-1:0] acc,
  output logic                 acc_ovf
);

  localparam int PW = 2*WIDTH;
  localparam int CW = $clog2(WIDTH) + 1;

  typedef enum logic [1:0] {S_IDLE, S_CALC, S_DONE} state_t;

  state_t               state_q, state_d;
  logic [CW-1:0]        cnt_q, cnt_d;
  logic [WIDTH-1:0]     mcand_q, mcand_d;
  logic [PW-1:0]        part_q, part_d;
  logic                 neg_q, neg_d;
  logic                 sgn_q, sgn_d;
  logic                 accop_q, accop_d;
  logic [PW-1:0]        product_q, product_d;
  logic [ACC_WIDTH-1:0] acc_q, acc_d;
  logic                 ovf_q, ovf_d;
  logic                 out_valid_q, out_valid_d;

  logic [WIDTH-1:0]     a_mag, b_mag;
  logic [WIDTH:0]       sum;
  logic [PW-1:0]        step, prod_fin;
  logic [ACC_WIDTH-1:0] ext;
  logic [ACC_WIDTH:0]   acc_sum;
  logic                 sovf;

  // Handshakes: a transfer happens on a rising edge where valid and ready are
  // both high; in_ready is high exactly in IDLE, out_valid exactly in DONE.
  assign in_ready  = (state_q == S_IDLE);
  assign out_valid = out_valid_q;
  assign product   = product_q;
  assign acc       = acc_q;
  assign acc_ovf   = ovf_q;

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    mcand_d     = mcand_q;
    part_d      = part_q;
    neg_d       = neg_q;
    sgn_d       = sgn_q;
    accop_d     = accop_q;
    product_d   = product_q;
    acc_d       = acc_q;
    ovf_d       = ovf_q;
    out_valid_d = out_valid_q;

    a_mag = (op_signed && a[WIDTH-1]) ? -a : a;
    b_mag = (op_signed && b[WIDTH-1]) ? -b : b;

    // Low half of the partial register holds the remaining multiplier bits;
    // the carry of the upper-half add shifts back in at the top.
    sum      = {1'b0, part_q[PW-1:WIDTH]} + (part_q[0] ? {1'b0, mcand_q} : '0);
    step     = {sum, part_q[WIDTH-1:1]};
    prod_fin = neg_q ? -step : step;
    ext      = sgn_q ? ACC_WIDTH'($signed(prod_fin)) : ACC_WIDTH'(prod_fin);
    acc_sum  = {1'b0, acc_q} + {1'b0, ext};
    sovf     = (acc_q[ACC_WIDTH-1] == ext[ACC_WIDTH-1]) &&
               (acc_sum[ACC_WIDTH-1] != acc_q[ACC_WIDTH-1]);

    case (state_q)
      S_IDLE: begin
        if (in_valid) begin
          mcand_d = a_mag;
          part_d  = {{WIDTH{1'b0}}, b_mag};
          neg_d   = op_signed & (a[WIDTH-1] ^ b[WIDTH-1]);
          sgn_d   = op_signed;
          accop_d = op_acc;
          cnt_d   = '0;
          state_d = S_CALC;
          if (acc_clr) begin
            acc_d = '0;
            ovf_d = 1'b0;
          end
        end
      end
      S_CALC: begin
        part_d = step;
        cnt_d  = cnt_q + CW'(1);
        if (cnt_q == CW'(WIDTH-1)) begin
          product_d = prod_fin;
          if (accop_q) begin
            acc_d = acc_sum[ACC_WIDTH-1:0];
            ovf_d = ovf_q | (sgn_q ? sovf : acc_sum[ACC_WIDTH]);
          end
          out_valid_d = 1'b1;
          state_d     = S_DONE;
        end
      end
      S_DONE: begin
        if (out_ready) begin
          out_valid_d = 1'b0;
          state_d     = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      cnt_q       <= '0;
      mcand_q     <= '0;
      part_q      <= '0;
      neg_q       <= 1'b0;
      sgn_q       <= 1'b0;
      accop_q     <= 1'b0;
      product_q   <= '0;
      acc_q       <= '0;
      ovf_q       <= 1'b0;
      out_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      mcand_q     <= mcand_d;
      part_q      <= part_d;
      neg_q       <= neg_d;
      sgn_q       <= sgn_d;
      accop_q     <= accop_d;
      product_q   <= product_d;
      acc_q       <= acc_d;
      ovf_q       <= ovf_d;
      out_valid_q <= out_valid_d;
    end
  end

endmodule

// File: tb/tb_seq_mac_mult.sv
// Directed plus randomized bench for seq_mac_mult (WIDTH=4, ACC_WIDTH=12)
// against an integer-arithmetic reference model.
module tb_seq_mac_mult;

  logic        clk;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [3:0]  a;
  logic [3:0]  b;
  logic        op_signed;
  logic        op_acc;
  logic        acc_clr;
  logic        out_valid;
  logic        out_ready;
  logic [7:0]  product;
  logic [11:0] acc;
  logic        acc_ovf;

  int         n_checks;
  int         n_pass;
  logic [7:0] exp_q[$];
  logic [7:0] last_prod;
  int         m_acc;
  bit         m_ovf;

  seq_mac_mult #(.WIDTH(4), .ACC_WIDTH(12)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .a(a), .b(b), .op_signed(op_signed), .op_acc(op_acc), .acc_clr(acc_clr),
    .out_valid(out_valid), .out_ready(out_ready), .product(product),
    .acc(acc), .acc_ovf(acc_ovf)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) n_pass = n_pass + 1;
    else $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
  endtask

  // Drives one operation and advances the reference model from the rules:
  // integer product, optional clear, then modulo-4096 accumulate.
  task automatic accept_op(input logic [3:0] ta, input logic [3:0] tb_v,
                           input bit s, input bit ac, input bit clr);
    int sa, sb, p, sv, guard;
    guard = 0;
    while (!in_ready && guard < 40) begin
      @(negedge clk);
      guard++;
    end
    check("ready_before_accept", in_ready, 1);
    a = ta; b = tb_v; op_signed = s; op_acc = ac; acc_clr = clr; in_valid = 1'b1;
    sa = s ? int'($signed(ta)) : int'(ta);
    sb = s ? int'($signed(tb_v)) : int'(tb_v);
    p  = sa * sb;
    exp_q.push_back(p[7:0]);
    if (clr) begin
      m_acc = 0;
      m_ovf = 1'b0;
    end
    if (ac) begin
      if (s) begin
        sv = ((m_acc >= 2048) ? m_acc - 4096 : m_acc) + p;
        if (sv > 2047 || sv < -2048) m_ovf = 1'b1;
      end else if (m_acc + p > 4095) begin
        m_ovf = 1'b1;
      end
      m_acc = ((m_acc + p) % 4096 + 4096) % 4096;
    end
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    acc_clr  = 1'b0;
    check("busy_after_accept", in_ready, 0);
    check("no_early_valid", out_valid, 0);
  endtask

  task automatic wait_result(input string tag);
    int lat;
    lat = 0;
    while (!out_valid && lat < 20) begin
      @(posedge clk);
      @(negedge clk);
      lat++;
    end
    check({tag, "_latency"}, lat, 4);
    if (exp_q.size() > 0) last_prod = exp_q.pop_front();
    check({tag, "_product"}, product, last_prod);
    check({tag, "_acc"}, acc, m_acc);
    check({tag, "_ovf"}, acc_ovf, m_ovf);
    check({tag, "_busy"}, in_ready, 0);
  endtask

  task automatic release_result(input string tag);
    out_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    out_ready = 1'b0;
    check({tag, "_valid_drop"}, out_valid, 0);
    check({tag, "_ready_again"}, in_ready, 1);
  endtask

  task automatic run_op(input string tag, input logic [3:0] ta, input logic [3:0] tb_v,
                        input bit s, input bit ac, input bit clr);
    accept_op(ta, tb_v, s, ac, clr);
    wait_result(tag);
    release_result(tag);
  endtask

  initial begin
    n_checks = 0; n_pass = 0; m_acc = 0; m_ovf = 1'b0; last_prod = '0;
    rst_n = 1'b0; in_valid = 1'b0; a = '0; b = '0; op_signed = 1'b0;
    op_acc = 1'b0; acc_clr = 1'b0; out_ready = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    check("rst_in_ready", in_ready, 1);
    check("rst_out_valid", out_valid, 0);
    check("rst_product", product, 0);
    check("rst_acc", acc, 0);
    check("rst_ovf", acc_ovf, 0);

    // unsigned and signed products
    run_op("u13x11", 4'd13, 4'd11, 1'b0, 1'b0, 1'b0);
    check("u13x11_const", last_prod, 8'h8F);
    run_op("s_m8xm8", 4'b1000, 4'b1000, 1'b1, 1'b0, 1'b0);
    check("s_m8xm8_const", last_prod, 8'h40);
    run_op("s_m3x5", 4'b1101, 4'd5, 1'b1, 1'b0, 1'b0);
    check("s_m3x5_const", last_prod, 8'hF1);
    run_op("s_0xm8", 4'd0, 4'b1000, 1'b1, 1'b0, 1'b0);
    check("s_0xm8_const", last_prod, 8'h00);

    // accumulate / clear
    run_op("acc_3x4", 4'd3, 4'd4, 1'b0, 1'b1, 1'b1);
    check("acc_3x4_const", acc, 12);
    run_op("acc_5x5", 4'd5, 4'd5, 1'b0, 1'b1, 1'b0);
    check("acc_5x5_const", acc, 37);
    run_op("noacc_7x7", 4'd7, 4'd7, 1'b0, 1'b0, 1'b0);
    check("noacc_7x7_const", acc, 37);
    run_op("acc_m2x3", 4'b1110, 4'd3, 1'b1, 1'b1, 1'b0);
    check("acc_m2x3_const", acc, 31);

    // unsigned overflow, sticky, cleared by acc_clr
    for (int i = 0; i < 19; i++) run_op("ovf_15x15", 4'd15, 4'd15, 1'b0, 1'b1, i == 0);
    check("ovf_acc_179", acc, 179);
    check("ovf_set", acc_ovf, 1);
    run_op("ovf_sticky", 4'd2, 4'd2, 1'b0, 1'b1, 1'b0);
    check("ovf_still_set", acc_ovf, 1);
    run_op("ovf_clear", 4'd1, 4'd1, 1'b0, 1'b0, 1'b1);
    check("ovf_cleared", acc_ovf, 0);

    // randomized operations
    for (int i = 0; i < 30; i++)
      run_op("rand", 4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)),
             1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
             ($urandom_range(0, 5) == 0));

    // backpressure in DONE
    accept_op(4'd9, 4'd7, 1'b0, 1'b1, 1'b0);
    wait_result("bp");
    repeat (10) begin
      in_valid = 1'($urandom_range(0, 1));
      a = 4'($urandom_range(0, 15));
      b = 4'($urandom_range(0, 15));
      @(posedge clk);
      @(negedge clk);
      check("bp_valid_held", out_valid, 1);
      check("bp_not_ready", in_ready, 0);
      check("bp_product_held", product, last_prod);
      check("bp_acc_held", acc, m_acc);
    end
    in_valid = 1'b0;
    release_result("bp");
    repeat (3) begin
      @(posedge clk);
      @(negedge clk);
      check("bp_single_transfer", out_valid, 0);
      check("bp_idle", in_ready, 1);
    end

    // reset during CALC iteration 2
    accept_op(4'd5, 4'd5, 1'b0, 1'b1, 1'b0);
    @(posedge clk);
    @(negedge clk);
    rst_n = 1'b0;
    @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    exp_q.delete();
    m_acc = 0;
    m_ovf = 1'b0;
    check("abort_ready", in_ready, 1);
    check("abort_valid", out_valid, 0);
    check("abort_acc", acc, 0);
    check("abort_ovf", acc_ovf, 0);
    run_op("post_rst_2x3", 4'd2, 4'd3, 1'b0, 1'b0, 1'b0);
    check("post_rst_const", last_prod, 8'd6);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
